mem_access_unit: RTL
====================

Name: mem_access_unit

Overview:
- Memory-stage front end for the byte-enabled 2048-word data memory (datamem).
- Decodes the MEM-stage load/store operation and address into word address, byte enables, write data and write strobe for datamem.
- Extracts and sign- or zero-extends the load result from the datamem read word.
- Registers the load result, destination register and address-exception status into the MEM/WB pipeline register that feeds write-back.

Parameters:
- ADDR_LIMIT, 32'h0000_2000, first byte address outside data memory (2048 words x 4 bytes).

Ports:
- Clk  input  1  clock, all state updates on rising edge.
- Reset  input  1  synchronous, active-high reset.
- En  input  1  pipeline advance. When 0, the MEM/WB register holds and stores are suppressed.
- Flush  input  1  kills the MEM-stage instruction. Takes priority over En.
- MemOp  input  4  operation: 0 none, 1 lw, 2 lh, 3 lhu, 4 lb, 5 lbu, 6 sw, 7 sh, 8 sb; 9-15 treated as none.
- Addr  input  32  byte address from ALU.
- StoreData  input  32  rt value for stores.
- Dst  input  5  destination register of the load.
- MemRD  input  32  datamem read word (combinational).
- MemA  output  11  datamem word address = Addr[12:2].
- MemBE  output  4  datamem byte enables.
- MemWD  output  32  datamem write data = StoreData unmodified; datamem takes byte/half data from the low lanes.
- MemWe  output  1  datamem write strobe.
- LoadData  output  32  registered extended load value.
- WbDst  output  5  registered destination.
- WbRegWrite  output  1  registered: load completed without exception.
- ExcCode  output  5  registered: 0 none, 4 AdEL, 5 AdES.
- BadVAddr  output  32  registered faulting address; 0 when ExcCode=0.

Behaviour:
- Classification of MemOp:
  - isLoad = MemOp in 1..5; isStore = MemOp in 6..8.
  - Misaligned: word op with Addr[1:0]!=0; half op with Addr[0]=1; byte ops never misaligned.
  - OutOfRange: Addr >= ADDR_LIMIT (unsigned).
  - fault = (isLoad or isStore) and (misaligned or OutOfRange).
- Byte enables (combinational; for a faulting op, MemBE still shows the decode and MemWe is 0):
  - sw: MemBE=1111.
  - sh: MemBE=0011 if Addr[1]=0, else 1100.
  - sb: MemBE = 0001 shifted left by Addr[1:0].
  - Loads and none: MemBE=0000.
- Write strobe: MemWe = isStore & ~fault & En & ~Flush. It is combinational; datamem commits on the same rising edge.
- Load extraction (combinational from MemRD, same cycle):
  - lw: MemRD.
  - lh/lhu: half = Addr[1] ? MemRD[31:16] : MemRD[15:0], then sign-extended (lh) or zero-extended (lhu).
  - lb/lbu: byte = MemRD[8*Addr[1:0]+7 -: 8], then sign-extended (lb) or zero-extended (lbu).
- MEM/WB register update, priority order:
  1. Reset=1: LoadData=0, WbDst=0, WbRegWrite=0, ExcCode=0, BadVAddr=0.
  2. Flush=1: same zero values (bubble).
  3. En=0: all hold.
  4. Otherwise:
     - LoadData = extracted value if isLoad & ~fault, else 0.
     - WbDst = Dst.
     - WbRegWrite = isLoad & ~fault.
     - ExcCode = 4 if isLoad & fault; 5 if isStore & fault; else 0.
     - BadVAddr = Addr if fault, else 0.
- Latency: load result is visible on LoadData 1 cycle after the request cycle. Stores produce no registered data.
- Back-to-back store then load to the same word: the store commits at edge N; the load presented in cycle N+1 reads the updated MemRD. No forwarding is required.
- Reset asserted mid-operation: a store presented in the same cycle still writes if MemWe=1; Reset does not gate MemWe. All registers clear on that edge.
- The block has no internal state besides the MEM/WB register.

Test Plan:
- sb Addr=0x0000_0013, StoreData=0x1234_5678 -> MemA=4, MemBE=1000, MemWD=0x1234_5678, MemWe=1; next cycle ExcCode=0, WbRegWrite=0.
- lh Addr=0x2 with MemRD=0x8001_7FFF, Dst=9 -> next cycle LoadData=0xFFFF_8001, WbDst=9, WbRegWrite=1.
  - Same stimulus as lhu -> LoadData=0x0000_8001.
  - lb Addr=0x1 -> LoadData=0x0000_007F.
- sw Addr=0x6 -> MemWe=0; next cycle ExcCode=5, BadVAddr=0x6.
  - lw Addr=0x2000 -> next cycle ExcCode=4, BadVAddr=0x2000, WbRegWrite=0.
- lw with En=0 for 3 cycles -> MemWe=0, all registered outputs hold their prior values.
  - Release En -> update on the next edge.
  - Flush=1 with En=0 -> registers zero.
- sw Addr=0x10, StoreData=0xDEAD_BEEF with Flush=1 -> MemWe=0.
  - Repeat with Flush=0, then lw Addr=0x10 -> LoadData=0xDEAD_BEEF.
- Reset pulse during a lw -> all registered outputs 0 the following cycle; normal operation resumes the next cycle.

Source files
------------

// File: rtl/mem_access_unit_if.sv
// mem_access_unit_if: the MEM-stage request, the datamem bus and the MEM/WB
// result bundle.
//   slave  : the mem_access_unit side. It takes the request and MemRD, and
//            drives the datamem controls and the write-back results.
//   master : the pipeline/datamem side, with the opposite directions.
interface mem_access_unit_if;
  logic        En;
  logic        Flush;
  logic [3:0]  MemOp;
  logic [31:0] Addr;
  logic [31:0] StoreData;
  logic [4:0]  Dst;
  logic [31:0] MemRD;
  logic [10:0] MemA;
  logic [3:0]  MemBE;
  logic [31:0] MemWD;
  logic        MemWe;
  logic [31:0] LoadData;
  logic [4:0]  WbDst;
  logic        WbRegWrite;
  logic [4:0]  ExcCode;
  logic [31:0] BadVAddr;

  modport slave (
    input  En, Flush, MemOp, Addr, StoreData, Dst, MemRD,
    output MemA, MemBE, MemWD, MemWe, LoadData, WbDst, WbRegWrite, ExcCode, BadVAddr
  );

  modport master (
    output En, Flush, MemOp, Addr, StoreData, Dst, MemRD,
    input  MemA, MemBE, MemWD, MemWe, LoadData, WbDst, WbRegWrite, ExcCode, BadVAddr
  );
endinterface

// File: rtl/mem_access_unit.sv
// mem_access_unit: memory-stage front end for the 2048-word byte-enabled datamem.
//   Clk    : clock. All state changes on the rising edge.
//   Reset  : synchronous, active-high. Clears the MEM/WB register.
//   bus    : mem_access_unit_if.slave
//            - request: En, Flush, MemOp, Addr, StoreData, Dst
//            - datamem: MemA, MemBE, MemWD, MemWe (out), MemRD (in, combinational)
//            - MEM/WB : LoadData, WbDst, WbRegWrite, ExcCode, BadVAddr (registered)
module mem_access_unit #(
  parameter logic [31:0] ADDR_LIMIT = 32'h0000_2000
) (
  input logic Clk,
  input logic Reset,
  mem_access_unit_if.slave bus
);

  localparam logic [3:0] OP_LW  = 4'd1;
  localparam logic [3:0] OP_LH  = 4'd2;
  localparam logic [3:0] OP_LHU = 4'd3;
  localparam logic [3:0] OP_LB  = 4'd4;
  localparam logic [3:0] OP_LBU = 4'd5;
  localparam logic [3:0] OP_SW  = 4'd6;
  localparam logic [3:0] OP_SH  = 4'd7;
  localparam logic [3:0] OP_SB  = 4'd8;

  localparam logic [4:0] EXC_NONE = 5'd0;
  localparam logic [4:0] EXC_ADEL = 5'd4;
  localparam logic [4:0] EXC_ADES = 5'd5;

  function automatic logic [31:0] sext16(input logic signed [15:0] v);
    logic signed [31:0] r;
    r = v;
    return r;
  endfunction

  function automatic logic [31:0] sext8(input logic signed [7:0] v);
    logic signed [31:0] r;
    r = v;
    return r;
  endfunction

  logic        is_load, is_store, misaligned, out_of_range, fault;
  logic [3:0]  be;
  logic [15:0] half_sel;
  logic [7:0]  byte_sel;
  logic [31:0] ext_data;

  logic [31:0] load_data_d,    load_data_q;
  logic [4:0]  wb_dst_d,       wb_dst_q;
  logic        wb_reg_write_d, wb_reg_write_q;
  logic [4:0]  exc_code_d,     exc_code_q;
  logic [31:0] bad_vaddr_d,    bad_vaddr_q;

  // Decode: classification, byte enables and load extraction
  always_comb begin
    is_load      = (bus.MemOp >= OP_LW) && (bus.MemOp <= OP_LBU);
    is_store     = (bus.MemOp >= OP_SW) && (bus.MemOp <= OP_SB);
    out_of_range = bus.Addr >= ADDR_LIMIT;
    misaligned   = 1'b0;
    be           = 4'b0000;
    case (bus.MemOp)
      OP_LW:             misaligned = bus.Addr[1:0] != 2'b00;
      OP_LH, OP_LHU:     misaligned = bus.Addr[0];
      OP_SW: begin
        misaligned = bus.Addr[1:0] != 2'b00;
        be         = 4'b1111;
      end
      OP_SH: begin
        misaligned = bus.Addr[0];
        be         = bus.Addr[1] ? 4'b1100 : 4'b0011;
      end
      OP_SB:             be = 4'b0001 << bus.Addr[1:0];
      default: ;
    endcase
    fault = (is_load || is_store) && (misaligned || out_of_range);

    half_sel = bus.Addr[1] ? bus.MemRD[31:16] : bus.MemRD[15:0];
    case (bus.Addr[1:0])
      2'd0:    byte_sel = bus.MemRD[7:0];
      2'd1:    byte_sel = bus.MemRD[15:8];
      2'd2:    byte_sel = bus.MemRD[23:16];
      default: byte_sel = bus.MemRD[31:24];
    endcase

    case (bus.MemOp)
      OP_LW:   ext_data = bus.MemRD;
      OP_LH:   ext_data = sext16(half_sel);
      OP_LHU:  ext_data = {16'h0000, half_sel};
      OP_LB:   ext_data = sext8(byte_sel);
      OP_LBU:  ext_data = {24'h000000, byte_sel};
      default: ext_data = 32'h0;
    endcase
  end

  // The write strobe deliberately ignores Reset: a store in the reset cycle still commits.
  assign bus.MemA  = bus.Addr[12:2];
  assign bus.MemBE = be;
  assign bus.MemWD = bus.StoreData;
  assign bus.MemWe = is_store && !fault && bus.En && !bus.Flush;

  // MEM/WB next state: Flush bubbles ahead of the En hold
  always_comb begin
    load_data_d    = load_data_q;
    wb_dst_d       = wb_dst_q;
    wb_reg_write_d = wb_reg_write_q;
    exc_code_d     = exc_code_q;
    bad_vaddr_d    = bad_vaddr_q;
    if (bus.Flush) begin
      load_data_d    = 32'h0;
      wb_dst_d       = 5'd0;
      wb_reg_write_d = 1'b0;
      exc_code_d     = EXC_NONE;
      bad_vaddr_d    = 32'h0;
    end else if (bus.En) begin
      load_data_d    = (is_load && !fault) ? ext_data : 32'h0;
      wb_dst_d       = bus.Dst;
      wb_reg_write_d = is_load && !fault;
      exc_code_d     = (is_load && fault)  ? EXC_ADEL :
                       (is_store && fault) ? EXC_ADES : EXC_NONE;
      bad_vaddr_d    = fault ? bus.Addr : 32'h0;
    end
  end

  // MEM/WB register
  always_ff @(posedge Clk) begin
    if (Reset) begin
      load_data_q    <= 32'h0;
      wb_dst_q       <= 5'd0;
      wb_reg_write_q <= 1'b0;
      exc_code_q     <= EXC_NONE;
      bad_vaddr_q    <= 32'h0;
    end else begin
      load_data_q    <= load_data_d;
      wb_dst_q       <= wb_dst_d;
      wb_reg_write_q <= wb_reg_write_d;
      exc_code_q     <= exc_code_d;
      bad_vaddr_q    <= bad_vaddr_d;
    end
  end

  assign bus.LoadData   = load_data_q;
  assign bus.WbDst      = wb_dst_q;
  assign bus.WbRegWrite = wb_reg_write_q;
  assign bus.ExcCode    = exc_code_q;
  assign bus.BadVAddr   = bad_vaddr_q;

endmodule
